clock_uart_tx: RTL

Serial time reporter for the HLS `Clock` core. It sits downstream of the core's `hh`/`mm`/`ss` outputs and watches them for a change. On each change it sends one ASCII line, `HH:MM:SS\r\n`, on a standard 8N1 UART transmit line. The bench or board can then log wall-clock time without probing the parallel bus.

---
 rtl/clock_uart_pkg.sv | 24 ++
 rtl/clock_uart_bin2dec.sv | 24 ++
 rtl/clock_uart_tx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/clock_uart_pkg.sv
// clock_uart_pkg
// Shared types and constants for the clock UART reporter.
//   state_t          : transmitter state (IDLE, START, DATA, STOP)
//   CHARS_PER_FRAME  : characters in one "HH:MM:SS\r\n" line
//   ASCII_*          : fixed characters used in the line and digit conversion
package clock_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int CHARS_PER_FRAME = 10;
  localparam logic [3:0] LAST_CHAR = 4'(CHARS_PER_FRAME - 1);

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

endpackage

// File: rtl/clock_uart_bin2dec.sv
// clock_uart_bin2dec
// Combinational conversion of an 8-bit unsigned value to two ASCII decimal
// digits. Values above 99 cannot be shown in two digits and become "??".
//   value : input  [7:0] unsigned binary value
//   tens  : output [7:0] ASCII tens digit (or '?')
//   ones  : output [7:0] ASCII ones digit (or '?')
module clock_uart_bin2dec
  import clock_uart_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] tens,
  output logic [7:0] ones
);

  always_comb begin
    tens = ASCII_QMARK;
    ones = ASCII_QMARK;
    if (value <= 8'd99) begin
      tens = ASCII_ZERO + (value / 8'd10);
      ones = ASCII_ZERO + (value % 8'd10);
    end
  end

endmodule

// File: rtl/clock_uart_tx.sv
// clock_uart_tx
// Watches the hh/mm/ss outputs of the Clock core and, whenever they change,
// transmits one "HH:MM:SS\r\n" line on an 8N1 UART output.
//   CLKS_PER_BIT : ap_clk cycles per UART bit (2..65535)
//   ap_clk       : clock, rising edge
//   ap_rst       : asynchronous active-high reset
//   en           : allows new frames to start (never aborts one in flight)
//   hh, mm, ss   : time inputs, unsigned binary
//   tx           : UART serial output, idles high
//   busy         : high while a frame is on the line
//   frame_done   : one-cycle pulse after the last stop bit
module clock_uart_tx
  import clock_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       ap_clk,
  input  logic       ap_rst,
  input  logic       en,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE = BAUD_W'(1);

  state_t            state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_idx, bit_next;
  logic [3:0]        char_idx, char_next;
  logic              done_next;

  logic [7:0] last_hh, last_mm, last_ss;
  logic [7:0] hh_buf, mm_buf, ss_buf;

  logic [7:0] h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
  logic [7:0] cur_char;

  logic trigger;
  logic bit_end;

  // A frame starts only from IDLE, and only when the time differs from the
  // one most recently sent. The last-sent copy is untouched while en=0, so a
  // change seen while disabled is still reported once en returns.
  assign trigger = (state == IDLE) && en &&
                   ({hh, mm, ss} != {last_hh, last_mm, last_ss});

  // The baud counter counts down and is reloaded on every bit boundary, so
  // each bit lasts exactly CLKS_PER_BIT cycles.
  assign bit_end = (baud_cnt == '0);

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    char_next  = char_idx;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_next = START;
          baud_next  = BAUD_MAX;
          char_next  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          baud_next  = BAUD_MAX;
          bit_next   = '0;
        end else begin
          baud_next = baud_cnt - BAUD_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next = BAUD_MAX;
          bit_next  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          baud_next = baud_cnt - BAUD_ONE;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next = BAUD_MAX;
          if (char_idx == LAST_CHAR) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            // Next character's start bit follows immediately, no idle gap.
            state_next = START;
            char_next  = char_idx + 4'd1;
          end
        end else begin
          baud_next = baud_cnt - BAUD_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      char_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_idx    <= bit_next;
      char_idx   <= char_next;
      frame_done <= done_next;
    end
  end

  // Reset to all-ones so the first valid time after reset always differs.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      last_hh <= 8'hFF;
      last_mm <= 8'hFF;
      last_ss <= 8'hFF;
    end else if (trigger) begin
      last_hh <= hh;
      last_mm <= mm;
      last_ss <= ss;
    end
  end

  // Frame buffer holds the snapshot so input changes mid-frame do not tear
  // the line being sent. It is only read while a frame is active.
  always_ff @(posedge ap_clk) begin
    if (trigger) begin
      hh_buf <= hh;
      mm_buf <= mm;
      ss_buf <= ss;
    end
  end

  clock_uart_bin2dec u_h (.value(hh_buf), .tens(h_tens), .ones(h_ones));
  clock_uart_bin2dec u_m (.value(mm_buf), .tens(m_tens), .ones(m_ones));
  clock_uart_bin2dec u_s (.value(ss_buf), .tens(s_tens), .ones(s_ones));

  always_comb begin
    cur_char = ASCII_LF;
    case (char_idx)
      4'd0:    cur_char = h_tens;
      4'd1:    cur_char = h_ones;
      4'd2:    cur_char = ASCII_COLON;
      4'd3:    cur_char = m_tens;
      4'd4:    cur_char = m_ones;
      4'd5:    cur_char = ASCII_COLON;
      4'd6:    cur_char = s_tens;
      4'd7:    cur_char = s_ones;
      4'd8:    cur_char = ASCII_CR;
      default: cur_char = ASCII_LF;
    endcase
  end

  // tx is decoded from registered state only, so asynchronous reset forces
  // it high immediately.
  always_comb begin
    tx = 1'b1;
    case (state)
      IDLE:    tx = 1'b1;
      START:   tx = 1'b0;
      DATA:    tx = cur_char[bit_idx];
      STOP:    tx = 1'b1;
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
